// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready
//   handshake on both sides.
//   Stage 1 forms the effective operand, per-bit generate/propagate and the
//   block generate/propagate for every GROUP-bit block.
//   Stage 2 resolves the carries by lookahead (across blocks, then inside
//   each block) and registers sum, cout, ovf and zero.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand set on A/B/cin/sub is valid
//   in_ready   : operand set is accepted this cycle
//   A, B       : operands (WIDTH bits)
//   cin        : carry-in for add (ignored when sub=1)
//   sub        : 0 = A+B+cin, 1 = A-B
//   out_valid  : result set is valid
//   out_ready  : consumer takes the result this cycle
//   sum        : result modulo 2^WIDTH
//   cout       : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        : two's-complement overflow
//   zero       : sum == 0
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NB = WIDTH / GROUP;  // number of lookahead blocks
  localparam int GL = GROUP - 1;      // bits per block that feed intra-block carries

  // Block generate: OR over j of g[j] & p[j+1] & ... & p[GROUP-1].
  // p_hi carries p[1..GROUP-1] of the block (p[0] never matters here).
  function automatic logic grp_gen(input logic [GROUP-1:0] g,
                                   input logic [GROUP-2:0] p_hi);
    logic acc;
    logic term;
    acc = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      term = g[j];
      for (int m = j + 1; m < GROUP; m++) term = term & p_hi[m-1];
      acc = acc | term;
    end
    return acc;
  endfunction

  // Carry into every block (index 0..NB-1) plus carry out of the top block
  // (index NB). Each carry is a flat sum of products, so no block-to-block
  // ripple exists.
  function automatic logic [NB:0] blk_carries(input logic [NB-1:0] gg,
                                              input logic [NB-1:0] pg,
                                              input logic          c0);
    logic [NB:0] c;
    logic        term;
    for (int k = 0; k <= NB; k++) begin
      term = c0;
      for (int m = 0; m < k; m++) term = term & pg[m];
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) term = term & pg[m];
        c[k] = c[k] | term;
      end
    end
    return c;
  endfunction

  // Carry into each bit of one block from its block carry-in. Only the low
  // GROUP-1 generate/propagate bits can influence a carry into the block.
  function automatic logic [GROUP-1:0] bit_carries(input logic [GROUP-2:0] g_lo,
                                                   input logic [GROUP-2:0] p_lo,
                                                   input logic             cblk);
    logic [GROUP-1:0] c;
    logic             term;
    for (int i = 0; i < GROUP; i++) begin
      term = cblk;
      for (int m = 0; m < i; m++) term = term & p_lo[m];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g_lo[j];
        for (int m = j + 1; m < i; m++) term = term & p_lo[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_load, s2_load;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // ---------------- stage 1 combinational ----------------
  logic [WIDTH-1:0] be_w, g_w, p_w;
  logic [NB-1:0]    gg_w, pg_w;
  logic [NB*GL-1:0] g_lo_w;

  assign be_w = sub ? ~B : B;
  assign g_w  = A & be_w;
  assign p_w  = A ^ be_w;

  for (genvar gi = 0; gi < NB; gi++) begin : g_blk1
    assign gg_w[gi]              = grp_gen(g_w[gi*GROUP +: GROUP], p_w[gi*GROUP+1 +: GL]);
    assign pg_w[gi]              = &p_w[gi*GROUP +: GROUP];
    assign g_lo_w[gi*GL +: GL]   = g_w[gi*GROUP +: GL];
  end

  // Stage 1 registers
  logic [WIDTH-1:0] p_q, p_d;
  logic [NB*GL-1:0] g_lo_q, g_lo_d;
  logic [NB-1:0]    gg_q, gg_d, pg_q, pg_d;
  logic             c0_q, c0_d;
  logic             a_msb_q, a_msb_d;
  logic             be_msb_q, be_msb_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    p_d        = p_q;
    g_lo_d     = g_lo_q;
    gg_d       = gg_q;
    pg_d       = pg_q;
    c0_d       = c0_q;
    a_msb_d    = a_msb_q;
    be_msb_d   = be_msb_q;
    if (s1_load) s1_valid_d = in_valid;
    // Data only moves on a real acceptance so idle inputs never touch state.
    if (s1_load && in_valid) begin
      p_d      = p_w;
      g_lo_d   = g_lo_w;
      gg_d     = gg_w;
      pg_d     = pg_w;
      c0_d     = sub | cin;
      a_msb_d  = A[WIDTH-1];
      be_msb_d = be_w[WIDTH-1];
    end
  end

  // ---------------- stage 2 combinational ----------------
  logic [NB:0]      blk_c_w;
  logic [WIDTH-1:0] c_w;
  logic [WIDTH-1:0] sum_w;
  logic             cout_w, ovf_w;

  assign blk_c_w = blk_carries(gg_q, pg_q, c0_q);

  for (genvar gi = 0; gi < NB; gi++) begin : g_blk2
    assign c_w[gi*GROUP +: GROUP] = bit_carries(g_lo_q[gi*GL +: GL],
                                                p_q[gi*GROUP +: GL],
                                                blk_c_w[gi]);
  end

  assign sum_w  = p_q ^ c_w;
  assign cout_w = blk_c_w[NB];
  // Carry-into-MSB xor carry-out, written in the operand-sign form: it only
  // differs from zero when both MSB operands agree and the sum sign flips.
  assign ovf_w  = (a_msb_q ~^ be_msb_q) & (sum_w[WIDTH-1] ^ a_msb_q);

  // Stage 2 registers
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  always_comb begin
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (s2_load) s2_valid_d = s1_valid_q;
    if (s2_load && s1_valid_q) begin
      sum_d  = sum_w;
      cout_d = cout_w;
      ovf_d  = ovf_w;
      zero_d = (sum_w == '0);
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_lo_q     <= '0;
      gg_q       <= '0;
      pg_q       <= '0;
      c0_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      be_msb_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      p_q        <= p_d;
      g_lo_q     <= g_lo_d;
      gg_q       <= gg_d;
      pg_q       <= pg_d;
      c0_q       <= c0_d;
      a_msb_q    <= a_msb_d;
      be_msb_q   <= be_msb_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout, ovf, zero;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  // Directed vectors; expected = {sum, cout, ovf, zero}, worked by hand.
  localparam int NV = 10;
  logic [15:0] va [NV] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000, 16'h0003,
                           16'h0005, 16'h8000, 16'h0010, 16'h00FF, 16'hFFFF};
  logic [15:0] vb [NV] = '{16'h0001, 16'h0001, 16'h4321, 16'h0001, 16'h0005,
                           16'h0005, 16'h8000, 16'h0001, 16'h0F01, 16'hFFFF};
  logic        vc [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        vs [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [18:0] vexp [NV] = '{{16'h0000, 1'b1, 1'b0, 1'b1},
                             {16'h8000, 1'b0, 1'b1, 1'b0},
                             {16'h5556, 1'b0, 1'b0, 1'b0},
                             {16'h7FFF, 1'b1, 1'b1, 1'b0},
                             {16'hFFFE, 1'b0, 1'b0, 1'b0},
                             {16'h0000, 1'b1, 1'b0, 1'b1},
                             {16'h0000, 1'b1, 1'b1, 1'b1},
                             {16'h000F, 1'b1, 1'b0, 1'b0},
                             {16'h1000, 1'b0, 1'b0, 1'b0},
                             {16'hFFFF, 1'b1, 1'b0, 1'b0}};

  typedef struct {
    logic [18:0] res;
    int          cyc;
  } exp_t;

  // Arithmetic reference: (A +/- B + c0) mod 2^16 with flags.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic s);
    logic [15:0] be;
    logic [16:0] full;
    logic        v;
    be   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {16'd0, (s ? 1'b1 : c)};
    v    = (a[15] == be[15]) && (full[15] != a[15]);
    return {full[15:0], full[16], v, (full[15:0] == 16'd0)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    A = va[i]; B = vb[i]; cin = vc[i]; sub = vs[i]; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({out_valid, sum, cout, ovf, zero} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", {out_valid, sum, cout, ovf, zero}, 20'h0);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    cyc();
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
    end
    $display("reset: outputs cleared, in_ready=%b", in_ready);
    cyc();
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(i);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      cyc();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_latency1[%0d]: got out_valid=%b want 0", i, out_valid);
      end
      cyc();
      n_vec++;
      if ({out_valid, sum, cout, ovf, zero} !== {1'b1, vexp[i]}) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: got %h want %h", i,
                 {out_valid, sum, cout, ovf, zero}, {1'b1, vexp[i]});
      end
      $display("directed %0d: A=%h B=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b zero=%b",
               i, va[i], vb[i], vc[i], vs[i], sum, cout, ovf, zero);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) drive(i);
      else in_valid = 1'b0;
      #1;
      n_vec++;
      if (i >= 2) begin
        if ({out_valid, sum, cout, ovf, zero} !== {1'b1, vexp[i-2]}) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got %h want %h", i - 2,
                   {out_valid, sum, cout, ovf, zero}, {1'b1, vexp[i-2]});
        end
        $display("b2b result %0d: sum=%h cout=%b ovf=%b zero=%b", i - 2, sum, cout, ovf, zero);
      end else if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_fill[%0d]: got out_valid=%b want 0", i, out_valid);
      end
      if (i < NV) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
        end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int  k;
    int  got;
    logic took;
    k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (k < 4) drive(k);
      else in_valid = 1'b0;
      #1;
      took = in_valid && in_ready;
      cyc();
      if (took) k++;
    end
    n_vec++;
    if (k !== 2) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d want 2", k);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({out_valid, sum, cout, ovf, zero} !== {1'b1, vexp[0]}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h want %h", c,
                 {out_valid, sum, cout, ovf, zero}, {1'b1, vexp[0]});
      end
      cyc();
    end
    $display("backpressure: accepted=%0d held sum=%h", k, sum);
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pass_through: got in_ready=%b want 1", in_ready);
    end
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (k < 4) drive(k);
      else in_valid = 1'b0;
      #1;
      took = in_valid && in_ready;
      if (out_valid) begin
        n_vec++;
        if ({sum, cout, ovf, zero} !== vexp[got]) begin
          n_fail++;
          $display("FAIL bp_drain[%0d]: got %h want %h", got, {sum, cout, ovf, zero}, vexp[got]);
        end
        $display("bp drain %0d: sum=%h cout=%b ovf=%b zero=%b", got, sum, cout, ovf, zero);
        got++;
      end
      cyc();
      if (took) k++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (got !== 4 || k !== 4) begin
      n_fail++;
      $display("FAIL bp_count: got delivered=%0d accepted=%0d want 4/4", got, k);
    end
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: got out_valid=%b want 0", out_valid);
    end
    cyc();
  endtask

  task automatic test_stream();
    exp_t q[$];
    exp_t e;
    int   accepted;
    logic exp_ov;
    logic exp_ir;
    accepted = 0;
    for (int t = 0; t < 5000 && accepted < 1000; t++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      A   = 16'($urandom);
      B   = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      #1;
      // The oldest outstanding set must be at the output exactly two cycles
      // after its acceptance unless it is still being held there.
      exp_ov = (q.size() > 0) && (q[0].cyc <= t - 2);
      exp_ir = (q.size() < 2) || out_ready;
      n_vec++;
      if (out_valid !== exp_ov || in_ready !== exp_ir) begin
        n_fail++;
        $display("FAIL stream_handshake[t=%0d]: got ov=%b ir=%b want ov=%b ir=%b",
                 t, out_valid, in_ready, exp_ov, exp_ir);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({sum, cout, ovf, zero} !== e.res) begin
          n_fail++;
          $display("FAIL stream_result[t=%0d]: got %h want %h", t, {sum, cout, ovf, zero}, e.res);
        end
      end
      if (in_valid && in_ready) begin
        e.res = model(A, B, cin, sub);
        e.cyc = t;
        q.push_back(e);
        accepted++;
      end
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 10 && q.size() > 0; t++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        n_vec++;
        if ({sum, cout, ovf, zero} !== e.res) begin
          n_fail++;
          $display("FAIL stream_drain: got %h want %h", {sum, cout, ovf, zero}, e.res);
        end
      end
      cyc();
    end
    n_vec++;
    if (q.size() !== 0 || accepted !== 1000) begin
      n_fail++;
      $display("FAIL stream_complete: got pending=%0d accepted=%0d want 0/1000", q.size(), accepted);
    end
    $display("stream: %0d operand sets accepted and checked", accepted);
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    drive(1);
    cyc();
    drive(2);
    cyc();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_full: got ov=%b ir=%b want ov=1 ir=0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, sum, cout, ovf, zero} !== 20'h0) begin
      n_fail++;
      $display("FAIL mr_async_clear: got %h want %h", {out_valid, sum, cout, ovf, zero}, 20'h0);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_in_ready: got %b want 1", in_ready);
    end
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mr_no_stale[%0d]: got ov=%b ir=%b want ov=0 ir=1", c, out_valid, in_ready);
      end
      cyc();
    end
    $display("mid-reset: pipeline flushed, out_valid=%b", out_valid);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_stream();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
